// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA block copier; reads words on port A and writes them on port B at one word per cycle.
// Define DMA_CSUM_EN to enable the running checksum of written words on csum (otherwise csum is tied to 0).
module mem_copy_engine #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] csum,
  output logic [AW-1:0] addra,
  output logic [3:0]    ena,
  output logic          wea,
  input  logic [DW-1:0] douta,
  output logic [AW-1:0] addrb,
  output logic [3:0]    enb,
  output logic          web,
  output logic [DW-1:0] dinb
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [AW-1:0] addra_d, addrb_d;
  logic          rd_en_d, wr_en_d;
  logic          busy_d, done_d;
  logic          csum_clr;

  // Next-state and next-output logic; every output register is loaded from its _d value.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    remain_d = remain_q;
    addra_d  = addra;
    addrb_d  = addrb;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    csum_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          csum_clr = 1'b1;
          wr_ptr_d = dst;
          if (len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            busy_d   = 1'b1;
            rd_en_d  = 1'b1;
            addra_d  = src;
            rd_ptr_d = src + AW'(1);
            remain_d = len - LW'(1);
          end
        end
      end
      RUN: begin
        // The read issued this cycle becomes a write next cycle.
        busy_d   = 1'b1;
        wr_en_d  = 1'b1;
        addrb_d  = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (remain_q != '0) begin
          rd_en_d  = 1'b1;
          addra_d  = rd_ptr_q;
          rd_ptr_d = rd_ptr_q + AW'(1);
          remain_d = remain_q - LW'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      remain_q <= '0;
      addra    <= '0;
      addrb    <= '0;
      ena      <= 4'h0;
      enb      <= 4'h0;
      web      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      remain_q <= remain_d;
      addra    <= addra_d;
      addrb    <= addrb_d;
      ena      <= rd_en_d ? 4'hF : 4'h0;
      enb      <= wr_en_d ? 4'hF : 4'h0;
      web      <= wr_en_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign wea = 1'b0;

  // Read data flows straight from port A to port B; forced to 0 outside write cycles.
  assign dinb = web ? douta : '0;

`ifdef DMA_CSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (csum_clr) begin
      csum_q <= '0;
    end else if (web) begin
      csum_q <= csum_q + dinb;
    end
  end

  assign csum = csum_q;
`else
  logic unused_csum_clr;

  assign unused_csum_clr = csum_clr;
  assign csum            = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: dual-port memory model plus read/write scoreboard queues fed by a copy model.
module tb_mem_copy_engine;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, wea, web;
  logic [DW-1:0] csum, douta, dinb;
  logic [AW-1:0] addra, addrb;
  logic [3:0]    ena, enb;

  logic [DW-1:0] mem   [MW];
  logic [DW-1:0] ref_m [MW];
  logic          fill, pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  logic [AW-1:0]    rd_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic [AW+DW-1:0] wr_e;
  logic [DW-1:0]    exp_csum;
  logic [DW-1:0]    saved [8];

  int vectors     = 0;
  int miscompares = 0;

  mem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .csum(csum),
    .addra(addra), .ena(ena), .wea(wea), .douta(douta),
    .addrb(addrb), .enb(enb), .web(web), .dinb(dinb)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hash(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: registered read on port A, write on port B, plus bench fill/preload.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MW; i++) mem[i] <= hash(i);
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
    if (ena != 4'h0) douta <= mem[addra];
    if (enb != 4'h0 && web) mem[addrb] <= dinb;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_nonempty(input string tag, input int sz, input logic [63:0] obs);
    vectors++;
    assert (sz != 0) else begin
      miscompares++;
      $error("FAIL %s unexpected transfer observed=%0h expected=none", tag, obs);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_enb"}, enb, 0);
    chk({tag, "_web"}, web, 0);
    chk({tag, "_wea"}, wea, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_addrb"}, addrb, 0);
    chk({tag, "_dinb"}, dinb, 0);
    chk({tag, "_csum"}, csum, 0);
  endtask

  // Scoreboard: every observed read/write must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ena != 4'h0) begin
        chk_nonempty("rd_unexpected", rd_q.size(), 64'(addra));
        if (rd_q.size() != 0) chk("rd_addr", addra, rd_q.pop_front());
        chk("ena_val", ena, 4'hF);
        chk("wea", wea, 0);
      end
      if (enb != 4'h0) begin
        chk_nonempty("wr_unexpected", wr_q.size(), 64'(addrb));
        if (wr_q.size() != 0) begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", addrb, wr_e[AW+DW-1:DW]);
          chk("wr_data", dinb, wr_e[DW-1:0]);
        end
        chk("enb_val", enb, 4'hF);
        chk("web", web, 1);
      end
    end
  end

  // Forward copy model: sequential word moves give memmove-forward semantics for dst<=src.
  task automatic push_model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] w;
    exp_csum = '0;
    for (int i = 0; i < n; i++) begin
      ra = s + AW'(i);
      wa = d + AW'(i);
      w  = ref_m[ra];
      ref_m[wa] = w;
      rd_q.push_back(ra);
      wr_q.push_back({wa, w});
      exp_csum = exp_csum + w;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] w);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = w;
    ref_m[a] = w;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input bit poke);
    int last;
    int span;
    logic [DW-1:0] ecs;
    logic [AW-1:0] wa;
    push_model(s, d, n);
`ifdef DMA_CSUM_EN
    ecs = exp_csum;
`else
    ecs = '0;
`endif
    last = (n == 0) ? 1 : n + 2;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = LW'(n);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start = poke;
      if (poke) begin
        src = AW'($urandom);
        dst = AW'($urandom);
        len = LW'($urandom_range(1, 9));
      end
      chk("busy", busy, (n > 0 && k <= n + 1));
      chk("done", done, (k == last));
      if (n == 0) begin
        chk("ena_zero_len", ena, 0);
        chk("enb_zero_len", enb, 0);
      end
    end
    chk("csum_at_done", csum, ecs);
    chk("rdq_left", rd_q.size(), 0);
    chk("wrq_left", wr_q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("csum_hold", csum, ecs);
    span = (n == 0) ? 4 : ((n > 64) ? 0 : n);
    for (int i = 0; i < span; i++) begin
      wa = d + AW'(i);
      chk("mem_dst", mem[wa], ref_m[wa]);
    end
  endtask

  initial begin
    logic [DW-1:0] ecs5;
    rst = 1'b0; fill = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    start = 1'($urandom); src = AW'($urandom); dst = AW'($urandom); len = LW'($urandom);
    for (int i = 0; i < MW; i++) ref_m[i] = hash(i);
    #2 rst = 1'b1;
    #1 chk_reset("reset_init");
    @(negedge clk);
    fill = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Basic copy.
    preload(14'h0010, 32'h1111_1111);
    preload(14'h0011, 32'h2222_2222);
    preload(14'h0012, 32'h3333_3333);
    preload(14'h0013, 32'h4444_4444);
    run_copy(14'h0010, 14'h0100, 4, 1'b0);
    chk("basic_word3", mem[14'h0103], 32'h4444_4444);

    // Zero length, address wrap, start pokes while busy, overlapping forward move.
    run_copy(14'h0030, 14'h0600, 0, 1'b0);
    run_copy(14'h3FFE, 14'h1000, 4, 1'b0);
    run_copy(14'h0040, 14'h0700, 6, 1'b1);
    run_copy(14'h0050, 14'h004E, 6, 1'b0);

    // Checksum with carry wrap.
    preload(14'h0020, 32'h0000_0001);
    preload(14'h0021, 32'h0000_0002);
    preload(14'h0022, 32'h0000_0003);
    preload(14'h0023, 32'hFFFF_FFFF);
    run_copy(14'h0020, 14'h0400, 4, 1'b0);
`ifdef DMA_CSUM_EN
    ecs5 = 32'h0000_0005;
`else
    ecs5 = 32'h0000_0000;
`endif
    chk("csum_value", csum, ecs5);

    // Abort with reset after the second write of an 8-word copy.
    for (int i = 0; i < 8; i++) saved[i] = ref_m[14'h0300 + AW'(i)];
    push_model(14'h0200, 14'h0300, 8);
    @(negedge clk);
    start = 1'b1; src = 14'h0200; dst = 14'h0300; len = LW'(8);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    start = 1'($urandom); src = AW'($urandom); dst = AW'($urandom); len = LW'($urandom);
    #1 chk_reset("reset_mid");
    rd_q.delete();
    wr_q.delete();
    for (int i = 2; i < 8; i++) ref_m[14'h0300 + AW'(i)] = saved[i];
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    for (int i = 0; i < 8; i++) chk("abort_mem", mem[14'h0300 + AW'(i)], ref_m[14'h0300 + AW'(i)]);

    // Whole-memory copy in place.
    run_copy(14'h0123, 14'h0123, MW, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
